// File: rtl/load_unit_ctrl.sv
// Load unit controller: one RISC-V load from core request through a valid/ready bus read to an aligned, extended result.
// Optional LOAD_SPLIT_MISALIGNED_EN: word-crossing non-AMO loads run two bus reads instead of trapping.
module load_unit_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic        amo,
  input  logic [31:0] addr,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_misaligned,
  output logic        rsp_fault,
  output logic [31:0] rsp_badaddr
);

  typedef enum logic [1:0] {IDLE, REQ0, REQ1, RESP} state_e;
  typedef enum logic [2:0] {K_LB, K_LH, K_LW, K_LBU, K_LHU} kind_e;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  state_e        state;
  kind_e         kind_q;
  logic [CW-1:0] wait_cnt;

  kind_e req_kind;
  logic  is_half, is_word, req_trap, timeout_hit;

  // AMO forces word semantics; the unused funct3 codes fall back to a signed byte.
  function automatic kind_e decode_kind(input logic [2:0] f3, input logic is_amo);
    if (is_amo) return K_LW;
    case (f3)
      3'b001:  return K_LH;
      3'b010:  return K_LW;
      3'b100:  return K_LBU;
      3'b101:  return K_LHU;
      default: return K_LB;
    endcase
  endfunction

  function automatic logic [31:0] extract(input kind_e k, input logic [1:0] off,
                                          input logic [31:0] hi, input logic [31:0] lo);
    logic [31:0] w;
    w = 32'({hi, lo} >> {off, 3'b000});
    case (k)
      K_LB:    return {{24{w[7]}}, w[7:0]};
      K_LBU:   return {24'h0, w[7:0]};
      K_LH:    return {{16{w[15]}}, w[15:0]};
      K_LHU:   return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  assign req_kind    = decode_kind(funct3, amo);
  assign is_half     = (req_kind == K_LH) || (req_kind == K_LHU);
  assign is_word     = (req_kind == K_LW);
  assign req_ready   = (state == IDLE);
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == LAST_WAIT);

`ifdef LOAD_SPLIT_MISALIGNED_EN
  logic        req_split, split_q;
  logic [31:0] lo_q;
  assign req_trap  = amo && (addr[1:0] != 2'b00);
  assign req_split = !amo && ((is_half && addr[1:0] == 2'b11) ||
                              (is_word && addr[1:0] != 2'b00));
`else
  assign req_trap  = (is_half && addr[0]) || (is_word && addr[1:0] != 2'b00);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: asynchronous reset clears every register, so an in-flight bus request is withdrawn immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      kind_q         <= K_LB;
      wait_cnt       <= '0;
      mem_valid      <= 1'b0;
      mem_addr       <= 32'h0;
      rsp_valid      <= 1'b0;
      rsp_data       <= 32'h0;
      rsp_misaligned <= 1'b0;
      rsp_fault      <= 1'b0;
      rsp_badaddr    <= 32'h0;
`ifdef LOAD_SPLIT_MISALIGNED_EN
      split_q        <= 1'b0;
      lo_q           <= 32'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            kind_q      <= req_kind;
            rsp_badaddr <= addr;
            wait_cnt    <= '0;
`ifdef LOAD_SPLIT_MISALIGNED_EN
            split_q     <= req_split;
`endif
            if (req_trap) begin
              state          <= RESP;
              rsp_valid      <= 1'b1;
              rsp_misaligned <= 1'b1;
              rsp_data       <= 32'h0;
            end else begin
              state     <= REQ0;
              mem_valid <= 1'b1;
              mem_addr  <= {addr[31:2], 2'b00};
            end
          end
        end

        REQ0: begin
          if (mem_ready) begin
`ifdef LOAD_SPLIT_MISALIGNED_EN
            if (split_q) begin
              lo_q     <= mem_rdata;
              state    <= REQ1;
              mem_addr <= mem_addr + 32'd4;
              wait_cnt <= '0;
            end else
`endif
            begin
              mem_valid <= 1'b0;
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= extract(kind_q, rsp_badaddr[1:0], 32'h0, mem_rdata);
            end
          end else if (timeout_hit) begin
            mem_valid <= 1'b0;
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b1;
            rsp_data  <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

`ifdef LOAD_SPLIT_MISALIGNED_EN
        REQ1: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= extract(kind_q, rsp_badaddr[1:0], mem_rdata, lo_q);
          end else if (timeout_hit) begin
            mem_valid <= 1'b0;
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b1;
            rsp_data  <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
`endif

        RESP: begin
          rsp_valid      <= 1'b0;
          rsp_misaligned <= 1'b0;
          rsp_fault      <= 1'b0;
          state          <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit_ctrl.sv
// Directed bench for load_unit_ctrl (TIMEOUT=4) with a two-word bus responder and a programmable stall.
// Expectations for misaligned loads follow LOAD_SPLIT_MISALIGNED_EN when it is defined for the build.
module tb_load_unit_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready;
  logic [2:0]  funct3;
  logic        amo;
  logic [31:0] addr;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_rdata;
  logic        rsp_valid, rsp_misaligned, rsp_fault;
  logic [31:0] rsp_data, rsp_badaddr;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] wa = 32'h0, da = 32'h0, wb = 32'h0, db = 32'h0;
  int stall = 0;
  int wait_cnt = 0;

  load_unit_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .funct3(funct3), .amo(amo), .addr(addr),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_misaligned(rsp_misaligned), .rsp_fault(rsp_fault),
    .rsp_badaddr(rsp_badaddr)
  );

  always #5 clk = ~clk;

  // Bus responder: two programmable words, ready after 'stall' wait cycles.
  always_comb begin
    mem_rdata = 32'hBAD0_BAD0;
    if (mem_addr == wa)      mem_rdata = da;
    else if (mem_addr == wb) mem_rdata = db;
  end

  assign mem_ready = mem_valid && (wait_cnt >= stall);

  always @(posedge clk) begin
    if (!mem_valid || mem_ready) wait_cnt <= 0;
    else                         wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one load, follow it to its response and check the whole transaction.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic a,
                         input logic [31:0] ad, input int exp_lat, input int exp_mv,
                         input logic [31:0] exp_a0, input logic [31:0] exp_a1,
                         input logic [31:0] exp_data, input logic exp_mis, input logic exp_flt);
    int lat, mv;
    logic [31:0] a0, a1;
    a0 = 32'h0;
    a1 = 32'h0;
    @(negedge clk);
    check({tag, "/req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    funct3    = f3;
    amo       = a;
    addr      = ad;
    @(negedge clk);
    req_valid = 1'b0;
    funct3    = 3'b111;
    amo       = ~a;
    addr      = ~ad;
    lat = 1;
    mv  = 0;
    while (!rsp_valid && lat < 20) begin
      if (mem_valid) begin
        if (mv == 0) a0 = mem_addr;
        else if (mv == 1) a1 = mem_addr;
        mv++;
      end
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/mem_cycles"}, 32'(mv), 32'(exp_mv));
    if (exp_mv > 0) check({tag, "/mem_addr0"}, a0, exp_a0);
    if (exp_mv > 1) check({tag, "/mem_addr1"}, a1, exp_a1);
    check({tag, "/rsp_data"}, rsp_data, exp_data);
    check({tag, "/misaligned"}, 32'(rsp_misaligned), 32'(exp_mis));
    check({tag, "/fault"}, 32'(rsp_fault), 32'(exp_flt));
    check({tag, "/badaddr"}, rsp_badaddr, ad);
    check({tag, "/mem_valid_at_rsp"}, 32'(mem_valid), 32'd0);
    @(negedge clk);
    check({tag, "/pulse_end"}, {29'h0, rsp_valid, rsp_misaligned, rsp_fault}, 32'd0);
    check({tag, "/idle_again"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn    = 1'b0;
    req_valid = 1'b0;
    funct3    = 3'b000;
    amo       = 1'b0;
    addr      = 32'h0;

    @(negedge clk);
    check("reset/req_ready", 32'(req_ready), 32'd1);
    check("reset/mem_valid", 32'(mem_valid), 32'd0);
    check("reset/mem_addr", mem_addr, 32'h0);
    check("reset/rsp_flags", {29'h0, rsp_valid, rsp_misaligned, rsp_fault}, 32'd0);
    check("reset/rsp_data", rsp_data, 32'h0);
    check("reset/rsp_badaddr", rsp_badaddr, 32'h0);
    resetn = 1'b1;

    // Aligned word, bus ready immediately: minimum latency.
    wa = 32'h100; da = 32'hDEAD_BEEF;
    do_load("lw_100", 3'b010, 1'b0, 32'h100, 2, 1, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Byte/half extraction and funct3 decode against word 0x80FF0000.
    da = 32'h80FF_0000;
    do_load("lb_103",   3'b000, 1'b0, 32'h103, 2, 1, 32'h100, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0);
    do_load("lbu_103",  3'b100, 1'b0, 32'h103, 2, 1, 32'h100, 32'h0, 32'h0000_0080, 1'b0, 1'b0);
    do_load("lh_102",   3'b001, 1'b0, 32'h102, 2, 1, 32'h100, 32'h0, 32'hFFFF_80FF, 1'b0, 1'b0);
    do_load("lhu_102",  3'b101, 1'b0, 32'h102, 2, 1, 32'h100, 32'h0, 32'h0000_80FF, 1'b0, 1'b0);
    do_load("lh_100",   3'b001, 1'b0, 32'h100, 2, 1, 32'h100, 32'h0, 32'h0000_0000, 1'b0, 1'b0);
    do_load("lb_102",   3'b000, 1'b0, 32'h102, 2, 1, 32'h100, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_load("f3_011",   3'b011, 1'b0, 32'h103, 2, 1, 32'h100, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0);
    do_load("f3_110",   3'b110, 1'b0, 32'h103, 2, 1, 32'h100, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0);
    do_load("f3_111",   3'b111, 1'b0, 32'h102, 2, 1, 32'h100, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_load("amo_f3_0", 3'b000, 1'b1, 32'h100, 2, 1, 32'h100, 32'h0, 32'h80FF_0000, 1'b0, 1'b0);

    // Bus stalls: short stall, ready in the last permitted wait cycle, then timeout.
    stall = 2;
    do_load("lw_stall2", 3'b010, 1'b0, 32'h100, 4, 3, 32'h100, 32'h100, 32'h80FF_0000, 1'b0, 1'b0);
    stall = 3;
    do_load("lw_stall3", 3'b010, 1'b0, 32'h100, 5, 4, 32'h100, 32'h100, 32'h80FF_0000, 1'b0, 1'b0);
    stall = 4;
    do_load("lh_timeout", 3'b001, 1'b0, 32'h102, 5, 4, 32'h100, 32'h100, 32'h0, 1'b0, 1'b1);
    stall = 0;

    // Byte load never misaligned.
    wa = 32'h200; da = 32'h1122_3344;
    do_load("lb_201", 3'b000, 1'b0, 32'h201, 2, 1, 32'h200, 32'h0, 32'h0000_0033, 1'b0, 1'b0);

    // AMO misaligned traps in every build.
    do_load("amo_202",  3'b001, 1'b1, 32'h202, 1, 0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    wa = 32'hFFFF_FFFC; da = 32'hAABB_CCDD;
    wb = 32'h0000_0000; db = 32'h1122_3344;
    do_load("amo_fffe", 3'b010, 1'b1, 32'hFFFF_FFFE, 1, 0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

`ifdef LOAD_SPLIT_MISALIGNED_EN
    do_load("lw_fffe", 3'b010, 1'b0, 32'hFFFF_FFFE, 3, 2, 32'hFFFF_FFFC, 32'h0, 32'h3344_AABB, 1'b0, 1'b0);
    wa = 32'h1FC; da = 32'hAABB_CCDD;
    wb = 32'h200; db = 32'h1122_3344;
    do_load("lhu_1ff", 3'b101, 1'b0, 32'h1FF, 3, 2, 32'h1FC, 32'h200, 32'h0000_44AA, 1'b0, 1'b0);
    do_load("lh_201", 3'b001, 1'b0, 32'h201, 2, 1, 32'h200, 32'h0, 32'h0000_2233, 1'b0, 1'b0);
`else
    do_load("lw_fffe", 3'b010, 1'b0, 32'hFFFF_FFFE, 1, 0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    do_load("lhu_1ff", 3'b101, 1'b0, 32'h1FF, 1, 0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    do_load("lh_201",  3'b001, 1'b0, 32'h201, 1, 0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
`endif

    // Reset while a bus read is outstanding.
    wa = 32'h100; da = 32'hCAFE_F00D;
    stall = 255;
    @(negedge clk);
    req_valid = 1'b1;
    funct3    = 3'b010;
    amo       = 1'b0;
    addr      = 32'h100;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mid/mem_valid_before", 32'(mem_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("rst_mid/mem_valid_async", 32'(mem_valid), 32'd0);
    check("rst_mid/req_ready_async", 32'(req_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    stall  = 0;
    @(negedge clk);
    check("rst_mid/idle_after", {30'h0, req_ready, rsp_valid}, 32'd2);
    do_load("lw_after_rst", 3'b010, 1'b0, 32'h100, 2, 1, 32'h100, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
